// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for the async FIFO, throttled by full/almost_full.
// Define WR_ARB_BURST_EN to let a granted producer keep the port for up to MAX_BURST writes.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                      wr_clk,
  input  logic                      rstn,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic                      wr_enbl_o,
  output logic [DATA_W-1:0]         wr_data_o,
  input  logic                      full_i,
  input  logic                      almost_full_i,
  input  logic                      overflow_i,
  output logic                      ovf_err_o,
  output logic [15:0]               wr_cnt_o
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
`ifdef WR_ARB_BURST_EN
  localparam int BURST_LIM = MAX_BURST;
`else
  // A burst limit of one degenerates to plain round-robin.
  localparam int BURST_LIM = 1;
`endif

  typedef enum logic [1:0] {IDLE, XFER, STALL} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   cur_q, cur_d;
  logic [CNT_W-1:0]   bcnt_q, bcnt_d;
  logic               we_q;
  logic [DATA_W-1:0]  data_q;
  logic [15:0]        cnt_q;
  logic               ovf_q;

  logic               space, hold, found, xfer;
  logic [PTR_W-1:0]   base, idx, rr_idx, sel;
  logic [DATA_W-1:0]  sel_data;
  int                 nxt;

  // A write already in flight takes the last free slot.
  always_comb begin
    space  = !full_i && !(almost_full_i && we_q);
    hold   = (bcnt_q != '0) && req_i[cur_q];
    base   = (bcnt_q != '0) ? cur_q : ptr_q;
    found  = 1'b0;
    idx    = '0;
    rr_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = PTR_W'((int'(base) + k) % NUM_REQ);
      if (!found && req_i[idx]) begin
        found  = 1'b1;
        rr_idx = idx;
      end
    end
    sel      = hold ? cur_q : rr_idx;
    xfer     = rstn && space && (hold || found);
    sel_data = req_data_i[int'(sel)*DATA_W +: DATA_W];
    gnt_o    = '0;
    if (xfer) gnt_o[sel] = 1'b1;
  end

  // Burst bookkeeping: ptr only moves when the owner's burst ends.
  always_comb begin
    ptr_d  = ptr_q;
    cur_d  = cur_q;
    bcnt_d = bcnt_q;
    nxt    = 0;
    if (xfer) begin
      nxt   = hold ? int'(bcnt_q) + 1 : 1;
      cur_d = sel;
      if (!hold && bcnt_q != '0) ptr_d = cur_q;
      if (nxt >= BURST_LIM) begin
        ptr_d  = sel;
        bcnt_d = '0;
      end else begin
        bcnt_d = CNT_W'(nxt);
      end
    end else if (bcnt_q != '0 && !req_i[cur_q]) begin
      ptr_d  = cur_q;
      bcnt_d = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (xfer)        state_d = XFER;
        else if (|req_i) state_d = STALL;
      end
      XFER, STALL: begin
        if (xfer)              state_d = XFER;
        else if (req_i == '0)  state_d = IDLE;
        else                   state_d = STALL;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wr_clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      ptr_q   <= PTR_W'(NUM_REQ - 1);
      cur_q   <= '0;
      bcnt_q  <= '0;
      we_q    <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cur_q   <= cur_d;
      bcnt_q  <= bcnt_d;
      we_q    <= xfer;
      if (xfer) begin
        data_q <= sel_data;
        cnt_q  <= cnt_q + 16'd1;
      end
      if (overflow_i) ovf_q <= 1'b1;
    end
  end

  assign wr_enbl_o = we_q;
  assign wr_data_o = data_q;
  assign wr_cnt_o  = cnt_q;
  assign ovf_err_o = ovf_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scenario bench for fifo_wr_arbiter; a posedge monitor pops expected writes from a scoreboard.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    gnt;
  logic            wr_enbl;
  logic [DW-1:0]   wr_data;
  logic            full, af, ovf;
  logic            ovf_err;
  logic [15:0]     wr_cnt;

  int              n_tests = 0;
  int              n_fail  = 0;
  logic [DW-1:0]   exp_q[$];
  logic            we_m = 1'b0;
  logic [15:0]     cnt_m = '0;
  bit              mon_en = 1'b0;
  logic [DW-1:0]   mon_exp;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(4)) dut (
    .wr_clk(clk), .rstn(rstn), .req_i(req), .req_data_i(req_data), .gnt_o(gnt),
    .wr_enbl_o(wr_enbl), .wr_data_o(wr_data), .full_i(full), .almost_full_i(af),
    .overflow_i(ovf), .ovf_err_o(ovf_err), .wr_cnt_o(wr_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  always @(posedge clk) begin
    #2;
    if (mon_en) begin
      n_tests++;
      if (wr_enbl !== we_m) begin
        n_fail++;
        $display("FAIL wr_enbl: got %b expected %b at %0t", wr_enbl, we_m, $time);
      end
      if (wr_enbl === 1'b1) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL wr_data: got unexpected write %h expected none at %0t", wr_data, $time);
        end else begin
          mon_exp = exp_q.pop_front();
          if (wr_data !== mon_exp) begin
            n_fail++;
            $display("FAIL wr_data: got %h expected %h at %0t", wr_data, mon_exp, $time);
          end
        end
      end
    end
  end

  function automatic logic [DW-1:0] pd(input int i);
    return req_data[i*DW +: DW];
  endfunction

  task automatic tick(input bit x, input logic [DW-1:0] d);
    if (x) begin
      exp_q.push_back(d);
      cnt_m++;
    end
    we_m = x;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rstn = 1'b0; req = '0; full = 1'b0; af = 1'b0; ovf = 1'b0;
    exp_q.delete(); we_m = 1'b0; cnt_m = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; req = 4'b1111; full = 1'b0; af = 1'b0; ovf = 1'b0;
    req_data = {8'h33, 8'h22, 8'h11, 8'h07};
    mon_en = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
    n_tests++; if (wr_enbl !== 1'b0) begin n_fail++; $display("FAIL reset_wr_enbl: got %b expected 0", wr_enbl); end
    n_tests++; if (wr_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_wr_cnt: got %h expected 0000", wr_cnt); end
    n_tests++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL reset_ovf_err: got %b expected 0", ovf_err); end
    rstn = 1'b1;
    #1;
    n_tests++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL reset_first_gnt: got %b expected 0001", gnt); end
    tick(gnt === 4'b0001, pd(0));
    req = '0;
    tick(1'b0, '0);
    n_tests++; if (wr_cnt !== 16'd1) begin n_fail++; $display("FAIL reset_cnt1: got %0d expected 1", wr_cnt); end
  endtask

`ifndef WR_ARB_BURST_EN
  task automatic test_round_robin();
    logic [N-1:0]  eg;
    logic [DW-1:0] d;
    int            g;
    do_reset();
    req_data = {8'h70, 8'h60, 8'h50, 8'h40};
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      g  = k % N;
      eg = N'(1) << g;
      n_tests++;
      if (gnt !== eg) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b expected %b", k, gnt, eg); end
      d = pd(g);
      tick(1'b1, d);
      req_data[g*DW +: DW] = d + 8'd1;
    end
    req = '0;
    tick(1'b0, '0);
    n_tests++; if (wr_cnt !== 16'd8) begin n_fail++; $display("FAIL rr_wr_cnt: got %0d expected 8", wr_cnt); end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rr_pending: got %0d expected 0", exp_q.size()); end
  endtask
`else
  task automatic test_burst();
    bit            full_t[11] = '{0,0,1,1,0,0,0,0,0,0,0};
    int            exp_t[11]  = '{0,0,-1,-1,0,0,1,1,1,1,0};
    logic [N-1:0]  eg;
    logic [DW-1:0] d;
    do_reset();
    req_data = {8'h00, 8'h00, 8'hB0, 8'hA0};
    req = 4'b0011;
    for (int c = 0; c < 11; c++) begin
      full = full_t[c];
      #1;
      eg = (exp_t[c] < 0) ? '0 : N'(1) << exp_t[c];
      n_tests++;
      if (gnt !== eg) begin n_fail++; $display("FAIL burst_gnt[%0d]: got %b expected %b", c, gnt, eg); end
      if (exp_t[c] >= 0) begin
        d = pd(exp_t[c]);
        tick(1'b1, d);
        req_data[exp_t[c]*DW +: DW] = d + 8'd1;
      end else begin
        tick(1'b0, '0);
      end
    end
    req = '0; full = 1'b0;
    tick(1'b0, '0);
    n_tests++; if (wr_cnt !== 16'd9) begin n_fail++; $display("FAIL burst_wr_cnt: got %0d expected 9", wr_cnt); end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL burst_pending: got %0d expected 0", exp_q.size()); end
  endtask
`endif

  task automatic test_backpressure();
    bit            full_t[9] = '{0,0,0,1,1,1,1,1,0};
    bit            af_t[9]   = '{0,1,1,0,0,0,0,0,0};
    logic          sp;
    logic [N-1:0]  eg;
    logic [DW-1:0] d;
    do_reset();
    req_data = {8'h00, 8'hC0, 8'h00, 8'h00};
    req = 4'b0100;
    for (int c = 0; c < 9; c++) begin
      full = full_t[c]; af = af_t[c];
      #1;
      sp = !full && !(af && we_m);
      eg = sp ? 4'b0100 : 4'b0000;
      n_tests++;
      if (gnt !== eg) begin n_fail++; $display("FAIL bp_gnt[%0d]: got %b expected %b", c, gnt, eg); end
      if (sp) begin
        d = pd(2);
        tick(1'b1, d);
        req_data[2*DW +: DW] = d + 8'd1;
      end else begin
        tick(1'b0, '0);
      end
    end
    req = '0; full = 1'b0; af = 1'b0;
    tick(1'b0, '0);
    n_tests++; if (wr_cnt !== 16'd3) begin n_fail++; $display("FAIL bp_wr_cnt: got %0d expected 3", wr_cnt); end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_pending: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_overflow_wrap();
    do_reset();
    ovf = 1'b1;
    tick(1'b0, '0);
    ovf = 1'b0;
    n_tests++; if (ovf_err !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", ovf_err); end
    repeat (3) tick(1'b0, '0);
    n_tests++; if (ovf_err !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", ovf_err); end
    n_tests++; if (wr_cnt !== 16'd0) begin n_fail++; $display("FAIL ovf_cnt: got %0d expected 0", wr_cnt); end
    do_reset();
    n_tests++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b expected 0", ovf_err); end
    req_data = {8'h00, 8'h00, 8'h00, 8'h5A};
    req = 4'b0001;
    for (int i = 0; i < 16'hFFFE; i++) tick(1'b1, 8'h5A);
    n_tests++; if (wr_cnt !== 16'hFFFE) begin n_fail++; $display("FAIL wrap_preload: got %h expected fffe", wr_cnt); end
    repeat (3) tick(1'b1, 8'h5A);
    req = '0;
    tick(1'b0, '0);
    n_tests++; if (wr_cnt !== 16'h0001) begin n_fail++; $display("FAIL wrap_cnt: got %h expected 0001", wr_cnt); end
    n_tests++; if (wr_cnt !== cnt_m) begin n_fail++; $display("FAIL wrap_model: got %h expected %h", wr_cnt, cnt_m); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    req_data = {8'h44, 8'h33, 8'hC1, 8'h11};
    req = 4'b0010;
    #1;
    n_tests++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL mr_gnt1: got %b expected 0010", gnt); end
    tick(1'b1, 8'hC1);
    req = 4'b1111;
    #2;
    rstn = 1'b0;
    exp_q.delete(); we_m = 1'b0; cnt_m = '0;
    #1;
    n_tests++; if (wr_enbl !== 1'b0) begin n_fail++; $display("FAIL mr_wr_enbl: got %b expected 0", wr_enbl); end
    n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL mr_gnt_rst: got %b expected 0000", gnt); end
    n_tests++; if (wr_cnt !== 16'd0) begin n_fail++; $display("FAIL mr_wr_cnt: got %0d expected 0", wr_cnt); end
    @(negedge clk);
    rstn = 1'b1;
    #1;
    n_tests++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL mr_restart: got %b expected 0001", gnt); end
    tick(gnt === 4'b0001, pd(0));
    req = '0;
    tick(1'b0, '0);
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL mr_pending: got %0d expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
`ifndef WR_ARB_BURST_EN
    test_round_robin();
`else
    test_burst();
`endif
    test_backpressure();
    test_overflow_wrap();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
